// File: rtl/panel_pkg.sv
// Shared front-panel definitions: scanner/shifter state encoding and default timing.
package panel_pkg;
  typedef enum logic [2:0] {LOAD, SETTLE, SHIFT, COMPARE, WAIT} state_t;

  localparam int PANEL_NBITS    = 72;
  localparam int PANEL_HALF     = 16;
  localparam int PANEL_LOAD     = 16;
  localparam int PANEL_WAIT     = 4096;
  localparam int PANEL_DEBOUNCE = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for asynchronous panel inputs.
module input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/switch_reader.sv
// Scans a '165-style switch chain, debounces whole words across scans and
// publishes the stable word to the panel controller.
module switch_reader
  import panel_pkg::*;
#(
  parameter int NBITS       = PANEL_NBITS,
  parameter int HALF        = PANEL_HALF,
  parameter int LOAD_CYCLES = PANEL_LOAD,
  parameter int WAIT_CYCLES = PANEL_WAIT,
  parameter int DEBOUNCE    = PANEL_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdata,
  output logic             sclk,
  output logic             sload_n,
  output logic [NBITS-1:0] switch_bits,
  output logic             switch_valid,
  output logic             switch_changed
);
  localparam int CMAX = max3(LOAD_CYCLES, HALF, WAIT_CYCLES);
  localparam int CW   = $clog2(CMAX);
  localparam int KW   = $clog2(NBITS);
  localparam int DW   = $clog2(DEBOUNCE + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [KW-1:0]    k;
  logic             high;
  logic [NBITS-1:0] scan;
  logic [NBITS-1:0] candidate;
  logic [DW-1:0]    count;
  logic             sdata_s;

  input_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sdata),
    .q     (sdata_s)
  );

  // Pin outputs are a registered decode of the state, so they trail it by one
  // clock; sampling at the end of the state's low phase therefore always lands
  // before the chain sees the matching sclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LOAD;
      cnt            <= '0;
      k              <= '0;
      high           <= 1'b0;
      scan           <= '0;
      candidate      <= '0;
      count          <= '0;
      sclk           <= 1'b0;
      sload_n        <= 1'b1;
      switch_bits    <= '0;
      switch_valid   <= 1'b0;
      switch_changed <= 1'b0;
    end else begin
      sload_n        <= (state != LOAD);
      sclk           <= (state == SHIFT) && high;
      switch_changed <= 1'b0;
      case (state)
        LOAD: begin
          if (cnt == CW'(LOAD_CYCLES - 1)) begin
            cnt   <= '0;
            state <= SETTLE;
          end else cnt <= cnt + CW'(1);
        end
        SETTLE: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            k     <= '0;
            high  <= 1'b0;
            state <= SHIFT;
          end else cnt <= cnt + CW'(1);
        end
        SHIFT: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!high) begin
              scan[k] <= sdata_s;
              high    <= 1'b1;
            end else begin
              high <= 1'b0;
              if (k == KW'(NBITS - 1)) state <= COMPARE;
              else k <= k + KW'(1);
            end
          end else cnt <= cnt + CW'(1);
        end
        COMPARE: begin
          if (scan != candidate || count == '0) begin
            candidate <= scan;
            count     <= DW'(1);
          end else if (count != DW'(DEBOUNCE)) begin
            count <= count + DW'(1);
          end
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0 && count == DW'(DEBOUNCE) &&
              (!switch_valid || candidate != switch_bits)) begin
            switch_bits    <= candidate;
            switch_valid   <= 1'b1;
            switch_changed <= 1'b1;
          end
          if (cnt == CW'(WAIT_CYCLES - 1)) begin
            cnt   <= '0;
            state <= LOAD;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
